// File: rtl/reg_strobe_array.sv
// Wishbone pipelined slave exposing NUM_REGS narrow fields with per-register write/read strobes.
// Optional read strobes (rd_o) are enabled by defining REG_STROBE_ARRAY_RD_STROBE_EN.
module reg_strobe_array #(
  parameter int unsigned       NUM_REGS    = 4,
  parameter int unsigned       DATA_W      = 1,
  parameter int unsigned       FIELD_LSB   = 1,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [5:0]                   wb_adr_i,
  input  logic [3:0]                   wb_sel_i,
  input  logic [31:0]                  wb_dat_i,
  output logic [31:0]                  wb_dat_o,
  output logic                         wb_ack_o,
  output logic                         wb_err_o,
  output logic                         wb_stall_o,
  output logic                         wb_rty_o,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
`ifdef REG_STROBE_ARRAY_RD_STROBE_EN
  output logic [NUM_REGS-1:0]          rd_o,
`endif
  output logic [NUM_REGS-1:0]          wr_o
);

  localparam int unsigned         REGS_W     = NUM_REGS * DATA_W;
  localparam logic [NUM_REGS-1:0] STROBE_ONE = NUM_REGS'(1);

  logic                wb_en;
  logic                accept;
  logic                mapped;
  logic [3:0]          idx;
  logic [DATA_W-1:0]   lane_mask;
  logic [DATA_W-1:0]   rd_field;
  logic [31:0]         rd_word;
  logic [REGS_W-1:0]   wr_full_mask;
  logic [REGS_W-1:0]   wr_full_data;

  logic                wr_busy_q;
  logic                rd_busy_q;
  logic                wr_pend_q;
  logic                wr_mapped_q;
  logic [3:0]          wr_idx_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [DATA_W-1:0]   wr_mask_q;
  logic [REGS_W-1:0]   fields_q;

  logic                unused_inputs;

  always_comb begin
    wb_en      = wb_cyc_i & wb_stb_i;
    accept     = wb_en & ~(wr_busy_q | rd_busy_q);
    idx        = wb_adr_i[5:2];
    mapped     = {28'd0, idx} < NUM_REGS;
    wb_stall_o = wb_en & ~(wb_ack_o | wb_err_o);
    wb_rty_o   = 1'b0;
    regs_o     = fields_q;
  end

  // Each field bit follows the byte lane it occupies in the 32-bit word.
  for (genvar i = 0; i < DATA_W; i++) begin : g_lane
    assign lane_mask[i] = wb_sel_i[(FIELD_LSB + i) / 8];
  end

  always_comb begin
    rd_field = DATA_W'(fields_q >> ({28'd0, idx} * DATA_W));
    rd_word  = '0;
    rd_word[FIELD_LSB +: DATA_W] = rd_field;
    wr_full_mask = REGS_W'(wr_mask_q) << ({28'd0, wr_idx_q} * DATA_W);
    wr_full_data = REGS_W'(wr_data_q) << ({28'd0, wr_idx_q} * DATA_W);
  end

  assign unused_inputs = ^{wb_adr_i[1:0], wb_dat_i, wb_sel_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fields_q    <= {NUM_REGS{RESET_VALUE}};
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= '0;
      wr_o        <= '0;
`ifdef REG_STROBE_ARRAY_RD_STROBE_EN
      rd_o        <= '0;
`endif
      wr_busy_q   <= 1'b0;
      rd_busy_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_mapped_q <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      wr_mask_q   <= '0;
    end else begin
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wr_o      <= '0;
`ifdef REG_STROBE_ARRAY_RD_STROBE_EN
      rd_o      <= '0;
`endif
      wr_pend_q <= 1'b0;

      // Flags drop at the end of the response cycle, so the next accept is one cycle later.
      if (wb_ack_o | wb_err_o) begin
        wr_busy_q <= 1'b0;
        rd_busy_q <= 1'b0;
      end

      if (accept) begin
        if (wb_we_i) begin
          wr_busy_q   <= 1'b1;
          wr_pend_q   <= 1'b1;
          wr_mapped_q <= mapped;
          wr_idx_q    <= idx;
          wr_data_q   <= wb_dat_i[FIELD_LSB +: DATA_W];
          wr_mask_q   <= lane_mask;
        end else begin
          rd_busy_q <= 1'b1;
          wb_ack_o  <= mapped;
          wb_err_o  <= ~mapped;
          wb_dat_o  <= mapped ? rd_word : 32'd0;
`ifdef REG_STROBE_ARRAY_RD_STROBE_EN
          rd_o      <= mapped ? (STROBE_ONE << idx) : '0;
`endif
        end
      end

      if (wr_pend_q) begin
        wb_ack_o <= wr_mapped_q;
        wb_err_o <= ~wr_mapped_q;
        if (wr_mapped_q) begin
          fields_q <= (fields_q & ~wr_full_mask) | (wr_full_data & wr_full_mask);
          wr_o     <= STROBE_ONE << wr_idx_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_strobe_array.sv
// Bench for reg_strobe_array: directed Wishbone traffic, a cycle-scheduled reference model,
// and hand-computed spot checks. Define REG_STROBE_ARRAY_RD_STROBE_EN to cover rd_o.
module tb_reg_strobe_array;

  localparam int          NR = 4;
  localparam int          DW = 8;
  localparam int          FL = 1;
  localparam logic [7:0]  RV = 8'h5A;
  localparam int          H  = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [5:0]  wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack, wb_err, wb_stall, wb_rty;
  logic [31:0] regs;
  logic [3:0]  wr;
`ifdef REG_STROBE_ARRAY_RD_STROBE_EN
  logic [3:0]  rd;
`endif

  reg_strobe_array #(
    .NUM_REGS(NR), .DATA_W(DW), .FIELD_LSB(FL), .RESET_VALUE(RV)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_sel_i(wb_sel), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack), .wb_err_o(wb_err),
    .wb_stall_o(wb_stall), .wb_rty_o(wb_rty),
    .regs_o(regs),
`ifdef REG_STROBE_ARRAY_RD_STROBE_EN
    .rd_o(rd),
`endif
    .wr_o(wr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: responses are booked into the cycle they must appear in.
  bit          sw_v [H];
  logic [3:0]  sw_idx [H];
  logic [7:0]  sw_d [H];
  logic [7:0]  sw_m [H];
  bit          sr_v [H];
  logic [3:0]  sr_idx [H];
  logic [31:0] sr_dat [H];
  logic [7:0]  mf [NR];
  logic [31:0] mdat;
  int          free_c = 0;
  bit          mvalid = 1'b0;

  function automatic logic [7:0] field_mask(input logic [3:0] sel);
    logic [7:0] m;
    for (int i = 0; i < DW; i++) m[i] = sel[(FL + i) / 8];
    return m;
  endfunction

  always @(negedge clk) begin
    int          c;
    logic        e_ack, e_err;
    logic [3:0]  e_wr, e_rd;
    c = cyc;
    if (mvalid && c < H) begin
      e_ack = 1'b0; e_err = 1'b0; e_wr = '0; e_rd = '0;
      if (sw_v[c]) begin
        if (sw_idx[c] < NR) begin
          mf[sw_idx[c]] = (mf[sw_idx[c]] & ~sw_m[c]) | (sw_d[c] & sw_m[c]);
          e_wr[sw_idx[c]] = 1'b1;
          e_ack = 1'b1;
        end else e_err = 1'b1;
      end
      if (sr_v[c]) begin
        if (sr_idx[c] < NR) begin
          e_ack = 1'b1;
          e_rd[sr_idx[c]] = 1'b1;
        end else e_err = 1'b1;
        mdat = sr_dat[c];
      end
      check("m_ack", {31'd0, wb_ack}, {31'd0, e_ack});
      check("m_err", {31'd0, wb_err}, {31'd0, e_err});
      check("m_wr", {28'd0, wr}, {28'd0, e_wr});
`ifdef REG_STROBE_ARRAY_RD_STROBE_EN
      check("m_rd", {28'd0, rd}, {28'd0, e_rd});
`endif
      check("m_dat", wb_dat_o, mdat);
      check("m_regs", regs, {mf[3], mf[2], mf[1], mf[0]});
      check("m_stall", {31'd0, wb_stall}, {31'd0, wb_cyc & wb_stb & ~(e_ack | e_err)});
      check("m_rty", {31'd0, wb_rty}, 32'd0);
    end
    if (rst) begin
      for (int k = c + 1; k <= c + 2 && k < H; k++) begin
        sw_v[k] = 1'b0;
        sr_v[k] = 1'b0;
      end
      for (int k = 0; k < NR; k++) mf[k] = RV;
      mdat   = '0;
      free_c = c + 1;
      mvalid = 1'b1;
    end else if (mvalid && wb_cyc && wb_stb && c >= free_c && c + 2 < H) begin
      if (wb_we) begin
        sw_v[c+2]   = 1'b1;
        sw_idx[c+2] = wb_adr[5:2];
        sw_d[c+2]   = 8'(wb_dat_i >> FL);
        sw_m[c+2]   = field_mask(wb_sel);
        free_c      = c + 3;
      end else begin
        sr_v[c+1]   = 1'b1;
        sr_idx[c+1] = wb_adr[5:2];
        sr_dat[c+1] = (wb_adr[5:2] < NR) ? (32'(mf[wb_adr[5:2]]) << FL) : 32'd0;
        free_c      = c + 2;
      end
    end
  end

  // Snapshots one and two cycles after the accept cycle.
  logic        s1_ack, s1_err, s2_ack, s2_err;
  logic [31:0] s1_dat, s2_regs;
  logic [3:0]  s1_wr, s2_wr, s1_rd;

  task automatic idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  // One-cycle request; cyc drops straight after the accept cycle.
  task automatic single(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat; wb_sel = sel;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    s1_ack = wb_ack; s1_err = wb_err; s1_dat = wb_dat_o; s1_wr = wr;
`ifdef REG_STROBE_ARRAY_RD_STROBE_EN
    s1_rd = rd;
`else
    s1_rd = '0;
`endif
    @(negedge clk);
    s2_ack = wb_ack; s2_err = wb_err; s2_regs = regs; s2_wr = wr;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    wb_adr = '0; wb_sel = '0; wb_dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_regs", regs, 32'h5A5A5A5A);
    check("rst_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_wr", {28'd0, wr}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    single(1'b0, 6'h08, 32'd0, 4'h0);
    check("rd2_ack", {31'd0, s1_ack}, 32'd1);
    check("rd2_dat", s1_dat, 32'h000000B4);
    check("rd2_wr", {28'd0, s1_wr}, 32'd0);

    // Only field bit 7 sits in lane 1; bits 6:0 keep the 0x5A reset value.
    single(1'b1, 6'h00, 32'hFFFFFFFE, 4'h2);
    check("wlane_t1_ack", {31'd0, s1_ack}, 32'd0);
    check("wlane_field", {24'd0, s2_regs[7:0]}, 32'h000000DA);
    check("wlane_wr", {28'd0, s2_wr}, 32'h1);
    check("wlane_ack", {31'd0, s2_ack}, 32'd1);

    single(1'b1, 6'h04, 32'h000001FE, 4'hF);
    check("w1_field", {24'd0, s2_regs[15:8]}, 32'h000000FF);
    check("w1_wr", {28'd0, s2_wr}, 32'h2);

    single(1'b0, 6'h14, 32'd0, 4'h0);
    check("rd5_err", {31'd0, s1_err}, 32'd1);
    check("rd5_ack", {31'd0, s1_ack}, 32'd0);
    check("rd5_dat", s1_dat, 32'd0);

    single(1'b1, 6'h1C, 32'hFFFFFFFF, 4'hF);
    check("w7_err", {31'd0, s2_err}, 32'd1);
    check("w7_ack", {31'd0, s2_ack}, 32'd0);
    check("w7_regs", s2_regs, 32'h5A5AFFDA);
    check("w7_wr", {28'd0, s2_wr}, 32'd0);

    // Write then read with stb held throughout.
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 6'h0C; wb_dat_i = 32'h66; wb_sel = 4'hF;
    @(negedge clk);
    check("b2b_t0_stall", {31'd0, wb_stall}, 32'd1);
    @(posedge clk); #1;
    wb_we = 1'b0;
    @(negedge clk);
    check("b2b_t1_stall", {31'd0, wb_stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_t2_ack", {31'd0, wb_ack}, 32'd1);
    check("b2b_t2_stall", {31'd0, wb_stall}, 32'd0);
    check("b2b_t2_wr", {28'd0, wr}, 32'h8);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_t3_ack", {31'd0, wb_ack}, 32'd0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("b2b_t4_ack", {31'd0, wb_ack}, 32'd1);
    check("b2b_t4_dat", wb_dat_o, 32'h00000066);

    // Reset lands while a write to index 3 is in flight.
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 6'h0C; wb_dat_i = 32'h1FE; wb_sel = 4'hF;
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 6'h0C;
    @(negedge clk);
    check("rstw_ack", {31'd0, wb_ack}, 32'd0);
    check("rstw_wr", {28'd0, wr}, 32'd0);
    check("rstw_regs", regs, 32'h5A5A5A5A);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("rstr_ack", {31'd0, wb_ack}, 32'd1);
    check("rstr_dat", wb_dat_o, 32'h000000B4);
`ifdef REG_STROBE_ARRAY_RD_STROBE_EN
    check("rstr_rd", {28'd0, rd}, 32'h8);
`endif

    // Lane-0-only write: bits 6:0 from data (0x55), bit 7 keeps reset 0.
    single(1'b1, 6'h08, 32'hAAAAAAAA, 4'h1);
    single(1'b0, 6'h0B, 32'd0, 4'h0);
    check("lane0_dat", s1_dat, 32'h000000AA);
`ifdef REG_STROBE_ARRAY_RD_STROBE_EN
    check("lane0_rd", {28'd0, s1_rd}, 32'h4);
`endif
    single(1'b1, 6'h08, 32'h00000000, 4'h0);
    check("sel0_wr", {28'd0, s2_wr}, 32'h4);
    check("sel0_field", {24'd0, s2_regs[23:16]}, 32'h00000055);
    single(1'b0, 6'h3C, 32'd0, 4'h0);
    check("rd15_err", {31'd0, s1_err}, 32'd1);
    single(1'b1, 6'h04, 32'h00000100, 4'h2);
    single(1'b0, 6'h05, 32'd0, 4'h0);
    check("rd1_dat", s1_dat, 32'h000001B4);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
